// File: rtl/register_file_mp.sv
// Multi-ported register file: two combinational read ports, one write port with
// optional same-cycle forwarding, per-register written flags, and a serial dump engine.
module register_file_mp #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int BYPASS = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic [ADDR_W-1:0]      wr_address,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic [ADDR_W-1:0]      rd_address_a,
    input  logic [ADDR_W-1:0]      rd_address_b,
    output logic [DATA_W-1:0]      rd_value_a,
    output logic [DATA_W-1:0]      rd_value_b,
    output logic [2**ADDR_W-1:0]   written,
    input  logic                   dump_start,
    output logic                   dump_valid,
    input  logic                   dump_ready,
    output logic [ADDR_W-1:0]      dump_address,
    output logic [DATA_W-1:0]      dump_data,
    output logic                   dump_last,
    output logic                   dump_busy
);

    localparam int DEPTH = 2**ADDR_W;
    localparam bit FORWARD = (BYPASS != 0);
    localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        DUMP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W-1:0] index_next;
    logic [DATA_W-1:0] regs [DEPTH];
    logic              beat_done;
    logic              at_last;

    assign at_last   = (index == LAST_INDEX);
    assign beat_done = (state == DUMP) && dump_ready;

    // A write to a register wins over a dump beat clearing its flag on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            written <= '0;
            state   <= IDLE;
            index   <= '0;
        end else begin
            if (ce) begin
                regs[wr_address] <= wr_data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (ce && (wr_address == ADDR_W'(i))) begin
                    written[i] <= 1'b1;
                end else if (beat_done && (index == ADDR_W'(i))) begin
                    written[i] <= 1'b0;
                end
            end
            state <= state_next;
            index <= index_next;
        end
    end

    always_comb begin
        state_next = state;
        index_next = index;
        case (state)
            IDLE: begin
                if (dump_start) begin
                    state_next = DUMP;
                    index_next = '0;
                end
            end
            DUMP: begin
                if (dump_ready) begin
                    if (at_last) begin
                        state_next = IDLE;
                        index_next = '0;
                    end else begin
                        index_next = index + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                index_next = '0;
            end
        endcase
    end

    always_comb begin
        rd_value_a = regs[rd_address_a];
        rd_value_b = regs[rd_address_b];
        if (FORWARD && ce && (wr_address == rd_address_a)) begin
            rd_value_a = wr_data;
        end
        if (FORWARD && ce && (wr_address == rd_address_b)) begin
            rd_value_b = wr_data;
        end
    end

    // Dump data always shows stored contents, never the forwarded write value.
    assign dump_valid   = (state == DUMP);
    assign dump_busy    = (state == DUMP);
    assign dump_address = index;
    assign dump_data    = regs[index];
    assign dump_last    = (state == DUMP) && at_last;

endmodule

// File: tb/tb_register_file_mp.sv
// Directed self-checking bench for register_file_mp: default, no-bypass and wide
// (16-bit data, 16-entry) instances driven through one linear sequence.
module tb_register_file_mp;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic [1:0] wr_address;
    logic [7:0] wr_data;
    logic [1:0] rd_address_a;
    logic [1:0] rd_address_b;
    logic       dump_start;
    logic       dump_ready;

    logic [7:0] rva, rvb, nb_rva, nb_rvb;
    logic [3:0] wr_flags, nb_wr_flags;
    logic       dv, dl, db, nb_dv, nb_dl, nb_db;
    logic [1:0] da, nb_da;
    logic [7:0] dd, nb_dd;

    logic        w_ce;
    logic [3:0]  w_wr_address;
    logic [15:0] w_wr_data;
    logic [3:0]  w_rd_a, w_rd_b;
    logic        w_dump_start, w_dump_ready;
    logic [15:0] w_rva, w_rvb, w_flags, w_dd;
    logic        w_dv, w_dl, w_db;
    logic [3:0]  w_da;

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    register_file_mp dut (
        .clk(clk), .rst(rst), .ce(ce), .wr_address(wr_address), .wr_data(wr_data),
        .rd_address_a(rd_address_a), .rd_address_b(rd_address_b),
        .rd_value_a(rva), .rd_value_b(rvb), .written(wr_flags),
        .dump_start(dump_start), .dump_valid(dv), .dump_ready(dump_ready),
        .dump_address(da), .dump_data(dd), .dump_last(dl), .dump_busy(db)
    );

    register_file_mp #(.DATA_W(8), .ADDR_W(2), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .ce(ce), .wr_address(wr_address), .wr_data(wr_data),
        .rd_address_a(rd_address_a), .rd_address_b(rd_address_b),
        .rd_value_a(nb_rva), .rd_value_b(nb_rvb), .written(nb_wr_flags),
        .dump_start(dump_start), .dump_valid(nb_dv), .dump_ready(dump_ready),
        .dump_address(nb_da), .dump_data(nb_dd), .dump_last(nb_dl), .dump_busy(nb_db)
    );

    register_file_mp #(.DATA_W(16), .ADDR_W(4), .BYPASS(1)) dut_w (
        .clk(clk), .rst(rst), .ce(w_ce), .wr_address(w_wr_address), .wr_data(w_wr_data),
        .rd_address_a(w_rd_a), .rd_address_b(w_rd_b),
        .rd_value_a(w_rva), .rd_value_b(w_rvb), .written(w_flags),
        .dump_start(w_dump_start), .dump_valid(w_dv), .dump_ready(w_dump_ready),
        .dump_address(w_da), .dump_data(w_dd), .dump_last(w_dl), .dump_busy(w_db)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] addr, input logic [7:0] data);
        ce         = we;
        wr_address = addr;
        wr_data    = data;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    initial begin
        logic [7:0]  exp_regs [4];
        logic [15:0] w_exp;
        int          beats;
        int          last_count;
        int          last_addr;

        rst = 1'b1; ce = 1'b0; wr_address = '0; wr_data = '0;
        rd_address_a = '0; rd_address_b = '0; dump_start = 1'b0; dump_ready = 1'b0;
        w_ce = 1'b0; w_wr_address = '0; w_wr_data = '0; w_rd_a = '0; w_rd_b = '0;
        w_dump_start = 1'b0; w_dump_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("reset_rva", 32'(rva), 0);
        checkOutput("reset_rvb", 32'(rvb), 0);
        checkOutput("reset_written", 32'(wr_flags), 0);
        checkOutput("reset_valid", 32'(dv), 0);
        checkOutput("reset_last", 32'(dl), 0);
        checkOutput("reset_busy", 32'(db), 0);
        checkOutput("reset_addr", 32'(da), 0);

        // Fill 0x11..0x44 and read back through both ports in opposite orders.
        exp_regs = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'(i), exp_regs[i]);
        end
        ce = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_address_a = 2'(i);
            rd_address_b = 2'(3 - i);
            #1;
            checkOutput($sformatf("fill_rva_%0d", i), 32'(rva), 32'(exp_regs[i]));
            checkOutput($sformatf("fill_rvb_%0d", i), 32'(rvb), 32'(exp_regs[3 - i]));
            checkOutput($sformatf("fill_nb_rva_%0d", i), 32'(nb_rva), 32'(exp_regs[i]));
        end
        checkOutput("fill_written", 32'(wr_flags), 32'h0000_000F);
        rd_address_a = 2'd1;
        #1;
        checkOutput("no_alias_addr1", 32'(rva), 32'h22);

        // Same-cycle forwarding vs. no forwarding.
        ce = 1'b1; wr_address = 2'd2; wr_data = 8'hA5;
        rd_address_a = 2'd2; rd_address_b = 2'd2;
        #1;
        checkOutput("bypass_rva", 32'(rva), 32'hA5);
        checkOutput("bypass_rvb", 32'(rvb), 32'hA5);
        checkOutput("nobypass_old", 32'(nb_rva), 32'h33);
        tick();
        ce = 1'b0; rd_address_b = 2'd3;
        #1;
        checkOutput("nobypass_next", 32'(nb_rva), 32'hA5);
        checkOutput("independent_rvb", 32'(rvb), 32'h44);
        exp_regs[2] = 8'hA5;

        // Dump with ready alternating 0,1; restart ignored and held-data write mid-dump.
        dump_start = 1'b1;
        #1;
        checkOutput("idle_busy", 32'(db), 0);
        tick();
        dump_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            dump_ready = 1'b0;
            if (k == 1) dump_start = 1'b1;
            if (k == 2) begin
                ce = 1'b1; wr_address = 2'd2; wr_data = 8'h77;
            end
            #1;
            checkOutput($sformatf("dump_valid_%0d", k), 32'(dv), 1);
            checkOutput($sformatf("dump_addr_%0d", k), 32'(da), 32'(k));
            checkOutput($sformatf("dump_data_%0d", k), 32'(dd), 32'(exp_regs[k]));
            checkOutput($sformatf("dump_last_%0d", k), 32'(dl), (k == 3) ? 1 : 0);
            tick();
            dump_start = 1'b0;
            ce = 1'b0;
            if (k == 2) exp_regs[2] = 8'h77;
            #1;
            checkOutput($sformatf("dump_hold_addr_%0d", k), 32'(da), 32'(k));
            checkOutput($sformatf("dump_hold_data_%0d", k), 32'(dd), 32'(exp_regs[k]));
            dump_ready = 1'b1;
            tick();
        end
        dump_ready = 1'b0;
        #1;
        checkOutput("dump_end_busy", 32'(db), 0);
        checkOutput("dump_end_valid", 32'(dv), 0);
        checkOutput("dump_end_written", 32'(wr_flags), 0);

        // Write to register 1 on the same edge its beat completes.
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        dump_ready = 1'b1;
        tick();
        ce = 1'b1; wr_address = 2'd1; wr_data = 8'h5A;
        tick();
        ce = 1'b0; dump_ready = 1'b0; rd_address_a = 2'd1;
        #1;
        checkOutput("wvc_written", 32'(wr_flags), 32'h2);
        checkOutput("wvc_reg1", 32'(rva), 32'h5A);
        checkOutput("wvc_index", 32'(da), 2);

        // Reset mid-dump, with a competing write and dump_start.
        rst = 1'b1; ce = 1'b1; wr_address = 2'd3; wr_data = 8'hEE; dump_start = 1'b1;
        tick();
        rst = 1'b0; ce = 1'b0; dump_start = 1'b0; rd_address_a = 2'd1; rd_address_b = 2'd3;
        #1;
        checkOutput("rst_busy", 32'(db), 0);
        checkOutput("rst_valid", 32'(dv), 0);
        checkOutput("rst_written", 32'(wr_flags), 0);
        checkOutput("rst_rva", 32'(rva), 0);
        checkOutput("rst_write_dropped", 32'(rvb), 0);
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        #1;
        checkOutput("restart_addr", 32'(da), 0);
        checkOutput("restart_valid", 32'(dv), 1);
        dump_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        dump_ready = 1'b0;
        #1;
        checkOutput("restart_done", 32'(db), 0);

        // Wide instance: 16 distinct writes, read back, full dump.
        for (int i = 0; i < 16; i++) begin
            w_ce = 1'b1;
            w_wr_address = 4'(i);
            w_wr_data = 16'hA000 + 16'(i) * 16'h0111;
            tick();
        end
        w_ce = 1'b0;
        for (int i = 0; i < 16; i++) begin
            w_rd_a = 4'(i);
            w_rd_b = 4'(15 - i);
            #1;
            w_exp = 16'hA000 + 16'(i) * 16'h0111;
            checkOutput($sformatf("wide_rva_%0d", i), 32'(w_rva), 32'(w_exp));
            w_exp = 16'hA000 + 16'(15 - i) * 16'h0111;
            checkOutput($sformatf("wide_rvb_%0d", i), 32'(w_rvb), 32'(w_exp));
        end
        checkOutput("wide_written", 32'(w_flags), 32'hFFFF);
        w_dump_start = 1'b1;
        tick();
        w_dump_start = 1'b0;
        w_dump_ready = 1'b1;
        beats = 0; last_count = 0; last_addr = -1;
        for (int c = 0; c < 40 && w_db; c++) begin
            w_exp = 16'hA000 + 16'(beats) * 16'h0111;
            checkOutput($sformatf("wide_dump_addr_%0d", beats), 32'(w_da), 32'(beats));
            checkOutput($sformatf("wide_dump_data_%0d", beats), 32'(w_dd), 32'(w_exp));
            if (w_dl) begin
                last_count++;
                last_addr = int'(w_da);
            end
            beats++;
            tick();
        end
        checkOutput("wide_beats", 32'(beats), 16);
        checkOutput("wide_last_count", 32'(last_count), 1);
        checkOutput("wide_last_addr", 32'(last_addr), 15);
        checkOutput("wide_written_clear", 32'(w_flags), 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 8: register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 2: address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter BYPASS, default 1: 1 forwards same-cycle write data to read ports; 0 disables forwarding.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port ce  input  1  write enable.
REQ-007 SHALL have port wr_address  input  ADDR_W  write register index.
REQ-008 SHALL have port wr_data  input  DATA_W  write data.
REQ-009 SHALL have ports rd_address_a / rd_address_b  input  ADDR_W  read indices, ports A and B.
REQ-010 SHALL have ports rd_value_a / rd_value_b  output  DATA_W  combinational read data.
REQ-011 SHALL have port written  output  DEPTH  per-register flag: written since last reset or dump.
REQ-012 SHALL have port dump_start  input  1  requests a serial dump of all registers.
REQ-013 SHALL have ports dump_valid (output, 1), dump_ready (input, 1): dump beat handshake.
REQ-014 SHALL have ports dump_address (output, ADDR_W), dump_data (output, DATA_W), dump_last (output, 1): beat index, contents, final-beat flag.
REQ-015 SHALL have port dump_busy  output  1  high while dump FSM is not IDLE.

Function
REQ-016 Register i SHALL load wr_data on the rising edge when ce=1 and wr_address=i; all other registers hold.
REQ-017 Each address SHALL map to exactly one distinct register, with no aliasing, for every ADDR_W.
REQ-018 rd_value_x SHALL equal reg[rd_address_x] combinationally (zero-cycle latency).
REQ-019 With BYPASS=1, ce=1 and rd_address_x=wr_address, rd_value_x SHALL equal wr_data in the same cycle.
REQ-020 With BYPASS=0, rd_value_x SHALL show the old contents until the edge after the write.
REQ-021 Both read ports SHALL be independent; equal addresses on A and B SHALL return identical data.
REQ-022 written[i] SHALL set on the edge that writes register i.
REQ-023 Dump FSM SHALL have two states, IDLE and DUMP, plus an index counter of ADDR_W bits.
REQ-024 IDLE: dump_valid=0 and dump_busy=0; dump_start=1 SHALL move the FSM to DUMP with index=0 on the next edge.
REQ-025 DUMP: dump_valid=1, dump_busy=1, dump_address=index, dump_data=reg[index] (stored contents, never bypassed), dump_last=(index=DEPTH-1).
REQ-026 A beat completes when dump_valid=1 and dump_ready=1; then index+1, or return to IDLE if dump_last=1.
REQ-027 With dump_ready=0, dump_address and index SHALL hold; dump_data SHALL track any write to the held register.
REQ-028 A completed beat SHALL clear written[dump_address], unless the same edge writes that register; the write wins and the bit stays 1.
REQ-029 dump_start SHALL be ignored while in DUMP; no restart and no index change.
REQ-030 Writes SHALL be accepted normally during DUMP; dump_start and a write in the same cycle SHALL both take effect.
REQ-031 Index SHALL never wrap; DEPTH beats per dump, exactly one with dump_last=1.

Reset
REQ-032 rst=1 at a rising edge SHALL clear all registers to 0, clear written to all zeros, force IDLE and clear index to 0.
REQ-033 rst SHALL take priority over ce and dump_start in the same cycle; the write is discarded.
REQ-034 rst during DUMP SHALL abort the dump; dump_valid=0 and dump_busy=0 from the next cycle.
REQ-035 After reset: rd_value_a/b=0, dump_valid=0, dump_last=0, dump_busy=0, dump_address=0, written=0.

Verification
REQ-036 Defaults: write 0x11,0x22,0x33,0x44 to addresses 0..3 -> reads return the same values, written=4'b1111; address 1 returns 0x22 (no alias).
REQ-037 Bypass: ce=1, wr_address=2, wr_data=0xA5, rd_address_a=2 -> rd_value_a=0xA5 same cycle; with BYPASS=0 -> old value, 0xA5 next cycle.
REQ-038 Dump with back-pressure: dump_start, dump_ready toggling 1,0,1,... -> beats at addresses 0,1,2,3 in order, dump_last only on 3, then IDLE; written=0.
REQ-039 Write-vs-clear: during DUMP, beat on address 1 completes while ce=1 writes 0x5A to address 1 -> written[1]=1, reg1=0x5A.
REQ-040 Reset mid-dump: rst at index 2 -> next cycle dump_busy=0, all reads 0, written=0; a later dump_start begins at address 0.
REQ-041 Parameters DATA_W=16, ADDR_W=4: 16 distinct writes and reads back, then a full dump -> 16 beats, last at address 15.
